// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg -- shared types and helpers for the program counter unit.
//
// Contents:
//   pc_op_e : operation applied to the PC in a given cycle.
//   pc_sel  : resolves the command inputs into one operation with the fixed
//             priority ret > call > jump > branch > increment. When en is low
//             the result is PC_HOLD, whatever else is asserted.
// ----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_op_e;

  function automatic pc_op_e pc_sel(input logic en,
                                    input logic ret,
                                    input logic call,
                                    input logic jump,
                                    input logic branch);
    pc_op_e op;
    if (!en)         op = PC_HOLD;
    else if (ret)    op = PC_RET;
    else if (call)   op = PC_CALL;
    else if (jump)   op = PC_JUMP;
    else if (branch) op = PC_BRANCH;
    else             op = PC_INC;
    return op;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// ----------------------------------------------------------------------------
// pc_ras -- circular return-address stack.
//
// A push writes at top+1 and advances top. A pop reads at top and moves top
// back. When the stack is full, a push lands on the oldest entry: that entry
// is overwritten and the count stays at DEPTH. A pop on an empty stack changes
// nothing. The unf_evt pulse reports it.
//
// Parameters:
//   DEPTH : number of entries. Must be a power of two and >= 2, so that the
//           top pointer wraps naturally.
//   WIDTH : width of each stored address.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push      : push push_data (never asserted together with pop)
//   pop       : discard the top entry
//   push_data : return address to store
//   top_data  : entry at the top pointer (valid when !empty)
//   cnt       : number of valid entries, 0..DEPTH
//   full      : cnt == DEPTH
//   empty     : cnt == 0
//   ovf_evt   : push attempted while full (combinational pulse)
//   unf_evt   : pop attempted while empty (combinational pulse)
// ----------------------------------------------------------------------------
module pc_ras
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       top_data,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf_evt,
  output logic                   unf_evt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign cnt      = cnt_q;
  assign top_data = mem_q[top_q];
  assign ovf_evt  = push & full;
  assign unf_evt  = pop & empty;

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d = top_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its pre-edge inputs regardless of the order of the statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage array has no reset. cnt_q == 0 already marks every
  // entry invalid, and leaving the array out of reset lets it map onto plain
  // RAM or register cells.
  always_ff @(posedge clk) begin
    if (push) mem_q[top_d] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit -- fetch-stage program counter with branch, jump and call/return.
//
// The PC is registered and addresses instruction memory directly. A command
// sampled at a rising edge is visible on pc after that edge. No combinational
// path runs from the inputs to pc. While en is high, each cycle performs one
// operation with the priority ret > call > jump > branch > increment. All PC
// arithmetic is modulo 2^WIDTH.
//
// Build option:
//   PC_RAS_EN defined   : the return-address stack is instantiated. call
//                         pushes pc+1, and ret pops into pc.
//   PC_RAS_EN undefined : there is no stack. call behaves as jump, and ret
//                         holds the PC. The RAS status outputs are constant
//                         (cnt=0, empty=1, others 0).
//
// Parameters: WIDTH (address width), OFFS_W (branch offset width, <= WIDTH),
//             DEPTH (RAS entries, power of two >= 2), RESET_VEC.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : advance enable. When low, everything holds except clr_err.
//   jump       : pc <= jump_addr
//   jump_addr  : target for jump and call
//   branch     : pc <= pc + sign-extended branch_off
//   branch_off : signed offset
//   call       : push pc+1, then pc <= jump_addr
//   ret        : pc <= popped return address
//   clr_err    : clear the sticky flags. A same-cycle set takes priority.
//   pc         : current program counter
//   ras_cnt, ras_full, ras_empty : stack occupancy
//   ras_ovf    : sticky; a call was made while the stack was full
//   ras_unf    : sticky; a ret was made while the stack was empty
// ----------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               OFFS_W    = 6,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   jump,
  input  logic [WIDTH-1:0]       jump_addr,
  input  logic                   branch,
  input  logic [OFFS_W-1:0]      branch_off,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       pc,
  output logic [$clog2(DEPTH):0] ras_cnt,
  output logic                   ras_full,
  output logic                   ras_empty,
  output logic                   ras_ovf,
  output logic                   ras_unf
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] off_ext;

  assign op      = pc_sel(en, ret, call, jump, branch);
  assign pc_inc  = pc_q + WIDTH'(1);
  // A sized cast of a signed operand sign-extends to WIDTH bits.
  assign off_ext = WIDTH'($signed(branch_off));
  assign pc      = pc_q;

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ovf_evt, unf_evt;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  pc_ras #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (op == PC_CALL),
    .pop       (op == PC_RET),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .cnt       (ras_cnt),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf_evt   (ovf_evt),
    .unf_evt   (unf_evt)
  );

  // A set event overrides a clear that arrives in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (unf_evt) unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign ras_cnt        = '0;
  assign ras_full       = 1'b0;
  assign ras_empty      = 1'b1;
  assign ras_ovf        = 1'b0;
  assign ras_unf        = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    case (op)
      PC_INC:    pc_d = pc_inc;
      PC_BRANCH: pc_d = pc_q + off_ext;
      PC_JUMP:   pc_d = jump_addr;
      PC_CALL:   pc_d = jump_addr;
      PC_RET: begin
`ifdef PC_RAS_EN
        if (!ras_empty) pc_d = ras_top;
`endif
      end
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VEC;
    else     pc_q <= pc_d;
  end

endmodule
